// File: rtl/calc_disp_pkg.sv
// Shared display definitions for the 7-seg calculator and its scan stage.
// Segment patterns are active-high internally, bit order {g,f,e,d,c,b,a}.
package calc_disp_pkg;

   localparam int SEG_W = 7;

   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   typedef logic [SEG_W-1:0] seg_t;

   localparam seg_t SEG_BLANK = 7'h00;
   localparam seg_t SEG_MINUS = 7'h40;

   // Scan slot phase: dark guard interval, then the digit is driven.
   typedef enum logic {
      PH_BLANK,
      PH_DRIVE
   } phase_e;

   // Hex digit to segment pattern, used by the calculator top.
   function automatic seg_t digit_seg(input logic [3:0] v);
      seg_t s;
      case (v)
         4'h0:    s = 7'h3F;
         4'h1:    s = 7'h06;
         4'h2:    s = 7'h5B;
         4'h3:    s = 7'h4F;
         4'h4:    s = 7'h66;
         4'h5:    s = 7'h6D;
         4'h6:    s = 7'h7D;
         4'h7:    s = 7'h07;
         4'h8:    s = 7'h7F;
         4'h9:    s = 7'h6F;
         4'hA:    s = 7'h77;
         4'hB:    s = 7'h7C;
         4'hC:    s = 7'h39;
         4'hD:    s = 7'h5E;
         4'hE:    s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/refresh_prescaler.sv
// Slot/digit counters for the display scan.
// Ports: clk, rst (sync, active-high); idx = digit being scanned,
// in_blank = slot guard interval, frame_end = last cycle of a frame,
// frame_first = first cycle of the digit-0 slot.
module refresh_prescaler
   import calc_disp_pkg::*;
#(
   parameter int N_DIGITS = 5,
   parameter int DIV      = 1000,
   parameter int BLANK    = 8,
   localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1,
   localparam int CW = $clog2(DIV)
) (
   input  logic          clk,
   input  logic          rst,
   output logic [IW-1:0] idx,
   output logic          in_blank,
   output logic          frame_end,
   output logic          frame_first
);

   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

   logic [CW-1:0] cnt;
   logic          cnt_wrap;
   logic          idx_wrap;

   assign cnt_wrap = (cnt == CNT_LAST);
   assign idx_wrap = (idx == IDX_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         idx <= '0;
      end else if (cnt_wrap) begin
         cnt <= '0;
         idx <= idx_wrap ? '0 : idx + IW'(1);
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign frame_end   = cnt_wrap && idx_wrap;
   assign frame_first = (cnt == '0) && (idx == '0);

   // A zero-length guard would make the compare constant.
   if (BLANK == 0) begin : g_noblank
      assign in_blank = 1'b0;
   end else begin : g_blank
      assign in_blank = (cnt < CW'(BLANK));
   end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexes N_DIGITS segment patterns onto one segment bus.
// Ports: clk, rst (sync, active-high); seg_in/upd_valid/upd_ready update
// handshake; seg_out, dig_en, frame_start registered display pins.
module seg_scan_mux
   import calc_disp_pkg::*;
#(
   parameter int N_DIGITS       = 5,
   parameter int DIV            = 1000,
   parameter int BLANK          = 8,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int DIG_ACTIVE_LOW = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [SEG_W*N_DIGITS-1:0] seg_in,
   input  logic                      upd_valid,
   output logic                      upd_ready,
   output logic [SEG_W-1:0]          seg_out,
   output logic [N_DIGITS-1:0]       dig_en,
   output logic                      frame_start
);

   localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   localparam seg_t SEG_OFF = {SEG_W{SEG_ACTIVE_LOW != 0}};
   localparam logic [N_DIGITS-1:0] DIG_OFF =
      {N_DIGITS{DIG_ACTIVE_LOW != 0}};

   logic [IW-1:0] idx;
   logic          in_blank;
   logic          frame_end;
   logic          frame_first;

   refresh_prescaler #(
      .N_DIGITS (N_DIGITS),
      .DIV      (DIV),
      .BLANK    (BLANK)
   ) u_presc (
      .clk         (clk),
      .rst         (rst),
      .idx         (idx),
      .in_blank    (in_blank),
      .frame_end   (frame_end),
      .frame_first (frame_first)
   );

   logic [SEG_W*N_DIGITS-1:0] pending;
   logic [SEG_W*N_DIGITS-1:0] shadow;
   logic                      pend_full;
   logic                      accept;

   assign upd_ready = !rst && (!pend_full || frame_end);
   assign accept    = upd_valid && upd_ready;

   // Shadow only changes at frame_end, so a frame never mixes images.
   // On a simultaneous accept the old pending commits first.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending   <= '0;
         shadow    <= '0;
         pend_full <= 1'b0;
      end else begin
         if (accept) begin
            pending <= seg_in;
         end
         if (frame_end) begin
            if (pend_full) begin
               shadow <= pending;
            end
            pend_full <= accept;
         end else if (accept) begin
            pend_full <= 1'b1;
         end
      end
   end

   phase_e                ph;
   seg_t                  seg_sel;
   logic [N_DIGITS-1:0]   dig_hot;
   seg_t                  seg_nx;
   logic [N_DIGITS-1:0]   dig_nx;

   assign ph      = in_blank ? PH_BLANK : PH_DRIVE;
   assign seg_sel = shadow[int'(idx)*SEG_W +: SEG_W];
   assign dig_hot = N_DIGITS'(1) << idx;

   always_comb begin
      seg_nx = SEG_BLANK;
      dig_nx = '0;
      unique case (ph)
         PH_BLANK: begin
            seg_nx = SEG_BLANK;
            dig_nx = '0;
         end
         PH_DRIVE: begin
            seg_nx = seg_sel;
            dig_nx = dig_hot;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         seg_out     <= SEG_OFF;
         dig_en      <= DIG_OFF;
         frame_start <= 1'b0;
      end else begin
         seg_out     <= seg_nx ^ SEG_OFF;
         dig_en      <= dig_nx ^ DIG_OFF;
         frame_start <= frame_first;
      end
   end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: directed table, corner sequences, random traffic.
// An active-low and an active-high instance share all inputs.
module tb_seg_scan_mux;

   localparam int N  = 5;
   localparam int DV = 10;
   localparam int BL = 2;
   localparam int FR = N * DV;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        upd_valid = 1'b0;
   logic [34:0] seg_in = '0;

   logic        upd_ready, frame_start;
   logic [6:0]  seg_out;
   logic [4:0]  dig_en;
   logic        ready_h, fs_h;
   logic [6:0]  seg_h;
   logic [4:0]  dig_h;

   always #5 clk = ~clk;

   seg_scan_mux #(
      .N_DIGITS(N), .DIV(DV), .BLANK(BL),
      .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
   ) u_lo (
      .clk(clk), .rst(rst), .seg_in(seg_in),
      .upd_valid(upd_valid), .upd_ready(upd_ready),
      .seg_out(seg_out), .dig_en(dig_en),
      .frame_start(frame_start)
   );

   seg_scan_mux #(
      .N_DIGITS(N), .DIV(DV), .BLANK(BL),
      .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
   ) u_hi (
      .clk(clk), .rst(rst), .seg_in(seg_in),
      .upd_valid(upd_valid), .upd_ready(ready_h),
      .seg_out(seg_h), .dig_en(dig_h),
      .frame_start(fs_h)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name,
                      input logic [34:0] act,
                      input logic [34:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: each accepted update is shown from the cycle after
   // the first frame end strictly after its acceptance cycle.
   typedef struct {
      int          acc;
      int          com;
      logic [34:0] pat;
   } upd_t;

   upd_t q[$];
   int   t = 0;

   function automatic logic [34:0] shadow_at(input int tt);
      logic [34:0] s = '0;
      foreach (q[i]) if (q[i].com < tt) s = q[i].pat;
      return s;
   endfunction

   function automatic logic ready_at(input int tt);
      foreach (q[i]) if (q[i].acc < tt && q[i].com > tt) return 1'b0;
      return 1'b1;
   endfunction

   typedef struct {
      int         p;
      logic [6:0] seg;
      logic [4:0] dig;
      logic       fs;
   } vec_t;

   vec_t tbl[12];
   logic tbl_on = 1'b0;
   int   tbl_lo = 0;

   logic [6:0] e_seg;
   logic [4:0] e_dig;
   logic       e_fs;
   int         e_t = -1;
   logic       have_exp = 1'b0;
   logic       last_acc = 1'b0;

   task automatic step(input logic r, input logic v,
                       input logic [34:0] s);
      int          p, d;
      logic [34:0] sh;
      logic        rd;
      logic [6:0]  ns;
      logic [4:0]  nd;
      @(negedge clk);
      if (have_exp) begin
         ns = ~e_seg;
         nd = ~e_dig;
         chk("seg_out", 35'(seg_out), 35'(e_seg));
         chk("dig_en", 35'(dig_en), 35'(e_dig));
         chk("frame_start", 35'(frame_start), 35'(e_fs));
         chk("seg_out_hi", 35'(seg_h), 35'(ns));
         chk("dig_en_hi", 35'(dig_h), 35'(nd));
         chk("frame_start_hi", 35'(fs_h), 35'(e_fs));
         if (tbl_on && e_t >= tbl_lo && e_t < tbl_lo + FR) begin
            foreach (tbl[i]) begin
               if (tbl[i].p == e_t - tbl_lo) begin
                  ns = ~tbl[i].seg;
                  nd = ~tbl[i].dig;
                  chk("tbl_seg", 35'(seg_out), 35'(tbl[i].seg));
                  chk("tbl_dig", 35'(dig_en), 35'(tbl[i].dig));
                  chk("tbl_fs", 35'(frame_start), 35'(tbl[i].fs));
                  chk("tbl_seg_hi", 35'(seg_h), 35'(ns));
                  chk("tbl_dig_hi", 35'(dig_h), 35'(nd));
               end
            end
         end
      end
      rst       = r;
      upd_valid = v;
      seg_in    = s;
      #1;
      last_acc = 1'b0;
      if (r) begin
         chk("upd_ready_rst", 35'(upd_ready), 35'(0));
         chk("upd_ready_rst_hi", 35'(ready_h), 35'(0));
         e_seg = 7'h7F;
         e_dig = 5'h1F;
         e_fs  = 1'b0;
         e_t   = -1;
         q.delete();
         t = 0;
      end else begin
         p  = t % FR;
         d  = p / DV;
         rd = ready_at(t);
         chk("upd_ready", 35'(upd_ready), 35'(rd));
         chk("upd_ready_hi", 35'(ready_h), 35'(rd));
         e_fs = (p == 0);
         e_t  = t;
         if (p % DV < BL) begin
            e_seg = 7'h7F;
            e_dig = 5'h1F;
         end else begin
            sh    = shadow_at(t);
            e_seg = ~sh[d*7 +: 7];
            e_dig = ~(5'd1 << d);
         end
         if (v && rd) begin
            last_acc = 1'b1;
            q.push_back('{t, (p == FR-1) ? t + FR : t + FR - 1 - p, s});
         end
         t++;
      end
      have_exp = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0);
   endtask

   task automatic run_to(input int p);
      for (int k = 0; k < FR; k++) begin
         if (t % FR == p) break;
         step(1'b0, 1'b0, '0);
      end
   endtask

   initial begin
      logic [63:0] rv;
      int          acc_p;

      tbl = '{
         '{0,  7'h7F, 5'h1F, 1'b1},
         '{1,  7'h7F, 5'h1F, 1'b0},
         '{2,  7'h40, 5'h1E, 1'b0},
         '{9,  7'h40, 5'h1E, 1'b0},
         '{10, 7'h7F, 5'h1F, 1'b0},
         '{11, 7'h7F, 5'h1F, 1'b0},
         '{12, 7'h79, 5'h1D, 1'b0},
         '{22, 7'h24, 5'h1B, 1'b0},
         '{32, 7'h30, 5'h17, 1'b0},
         '{42, 7'h19, 5'h0F, 1'b0},
         '{49, 7'h19, 5'h0F, 1'b0},
         '{48, 7'h19, 5'h0F, 1'b0}
      };

      // Reset, release, frame_start one cycle later.
      repeat (3) step(1'b1, 1'b0, '0);
      step(1'b0, 1'b0, '0);

      // Load digits, commit at first frame end, check frame 1.
      step(1'b0, 1'b1, {7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F});
      tbl_lo = FR;
      tbl_on = 1'b1;
      idle(110);
      tbl_on = 1'b0;

      // Mid-frame update must not tear the current frame.
      run_to(23);
      step(1'b0, 1'b1, {5{7'h7F}});
      idle(80);

      // Second update held while pending is full.
      run_to(5);
      step(1'b0, 1'b1, {7'h06, 7'h06, 7'h06, 7'h06, 7'h06});
      run_to(10);
      acc_p = -1;
      for (int k = 0; k < 4 * FR; k++) begin
         step(1'b0, 1'b1, {7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D});
         if (last_acc) begin
            acc_p = (t - 1) % FR;
            break;
         end
      end
      chk("held_accept", 35'(last_acc), 35'(1));
      chk("held_accept_cycle", 35'(acc_p), 35'(FR - 1));
      idle(150);

      // Reset mid-slot at idx=3, cnt=6.
      run_to(36);
      step(1'b1, 1'b0, '0);
      idle(60);

      // Random traffic with occasional resets.
      for (int k = 0; k < 2000; k++) begin
         rv = {$urandom, $urandom};
         step($urandom_range(0, 299) == 0,
              $urandom_range(0, 3) == 0, rv[34:0]);
      end
      step(1'b0, 1'b0, '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
